// File: rtl/hsv2rgb_pipe.sv
// hsv2rgb_pipe: pipelined HSV-to-RGB converter placed after the green-screen keyer.
// Inputs are captured on the sampling edge. Three further register stages follow,
// so a pixel sampled at edge N reaches the outputs after edge N+3.
// Row, col, the pass-through word, the valid bit and the en bit all travel
// through the pipe together with the pixel.
module hsv2rgb_pipe #(
  parameter int HUE_MAX = 360,
  parameter int RECIP60 = 1093
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic [12:0] row,
  input  logic [12:0] col,
  input  logic [23:0] pixel_in,
  input  logic [23:0] pass_in,
  output logic        out_valid,
  output logic [12:0] row_out,
  output logic [12:0] col_out,
  output logic [23:0] pixel_out,
  output logic [23:0] pass_thru
);

  // stage 1: raw capture
  logic        v1_valid, v1_en;
  logic [8:0]  h1;
  logic [6:0]  s1;
  logic [7:0]  val1;
  logic [23:0] pix1, pass1;
  logic [12:0] row1, col1;

  // stage 2: sector / f / chroma
  logic        v2_valid, v2_en;
  logic [2:0]  sector2;
  logic [5:0]  f2;
  logic [7:0]  c2, val2;
  logic [23:0] pix2, pass2;
  logic [12:0] row2, col2;

  // stage 3: g / m
  logic        v3_valid, v3_en;
  logic [2:0]  sector3;
  logic [6:0]  g3;
  logic [7:0]  c3, m3;
  logic [23:0] pix3, pass3;
  logic [12:0] row3, col3;

  // combinational intermediates
  logic [8:0]  h_fix;
  logic [8:0]  base;
  logic [2:0]  sector;
  logic [5:0]  f;
  logic [15:0] c_prod;
  logic [7:0]  c;
  logic [6:0]  g;
  logic [7:0]  m;
  logic [23:0] x_prod;
  logic [7:0]  x;
  logic [7:0]  r_ch, g_ch, b_ch;
  logic [23:0] rgb;

  // Capture the incoming pixel and its side-band unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_valid <= 1'b0;
      v1_en    <= 1'b0;
      h1       <= '0;
      s1       <= '0;
      val1     <= '0;
      pix1     <= '0;
      pass1    <= '0;
      row1     <= '0;
      col1     <= '0;
    end else begin
      v1_valid <= in_valid;
      v1_en    <= en;
      h1       <= pixel_in[23:15];
      s1       <= pixel_in[14:8];
      val1     <= pixel_in[7:0];
      pix1     <= pixel_in;
      pass1    <= pass_in;
      row1     <= row;
      col1     <= col;
    end
  end

  // Clamp invalid hue, locate the 60-degree sector and scale V by saturation.
  always_comb begin
    h_fix = (32'(h1) >= HUE_MAX) ? 9'd0 : h1;
    if (h_fix >= 9'd300) begin
      sector = 3'd5;
      base   = 9'd300;
    end else if (h_fix >= 9'd240) begin
      sector = 3'd4;
      base   = 9'd240;
    end else if (h_fix >= 9'd180) begin
      sector = 3'd3;
      base   = 9'd180;
    end else if (h_fix >= 9'd120) begin
      sector = 3'd2;
      base   = 9'd120;
    end else if (h_fix >= 9'd60) begin
      sector = 3'd1;
      base   = 9'd60;
    end else begin
      sector = 3'd0;
      base   = 9'd0;
    end
    f = 6'(h_fix - base);
    // S + S[6] maps 127 to 128 so full saturation yields C = V exactly.
    c_prod = 16'(val1) * (16'(s1) + 16'(s1[6]));
    c      = 8'(c_prod >> 7);
  end

  // Register sector, fractional hue and chroma.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_valid <= 1'b0;
      v2_en    <= 1'b0;
      sector2  <= '0;
      f2       <= '0;
      c2       <= '0;
      val2     <= '0;
      pix2     <= '0;
      pass2    <= '0;
      row2     <= '0;
      col2     <= '0;
    end else begin
      v2_valid <= v1_valid;
      v2_en    <= v1_en;
      sector2  <= sector;
      f2       <= f;
      c2       <= c;
      val2     <= val1;
      pix2     <= pix1;
      pass2    <= pass1;
      row2     <= row1;
      col2     <= col1;
    end
  end

  // Odd sectors run the ramp downwards; m lifts every channel to the V level.
  always_comb begin
    g = sector2[0] ? (7'd60 - {1'b0, f2}) : {1'b0, f2};
    m = val2 - c2;
  end

  // Register the ramp position and offset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3_valid <= 1'b0;
      v3_en    <= 1'b0;
      sector3  <= '0;
      g3       <= '0;
      c3       <= '0;
      m3       <= '0;
      pix3     <= '0;
      pass3    <= '0;
      row3     <= '0;
      col3     <= '0;
    end else begin
      v3_valid <= v2_valid;
      v3_en    <= v2_en;
      sector3  <= sector2;
      g3       <= g;
      c3       <= c2;
      m3       <= m;
      pix3     <= pix2;
      pass3    <= pass2;
      row3     <= row2;
      col3     <= col2;
    end
  end

  // X = C*g/60 via the Q0.16 reciprocal, then assign channels by sector.
  always_comb begin
    x_prod = 24'(c3) * 24'(g3) * 24'(RECIP60);
    x      = 8'(x_prod >> 16);
    r_ch   = 8'd0;
    g_ch   = 8'd0;
    b_ch   = 8'd0;
    case (sector3)
      3'd0: begin r_ch = c3; g_ch = x;  end
      3'd1: begin r_ch = x;  g_ch = c3; end
      3'd2: begin g_ch = c3; b_ch = x;  end
      3'd3: begin g_ch = x;  b_ch = c3; end
      3'd4: begin r_ch = x;  b_ch = c3; end
      default: begin r_ch = c3; b_ch = x; end
    endcase
    rgb = {r_ch + m3, g_ch + m3, b_ch + m3};
  end

  // Output register; bypassed pixels leave exactly as they arrived.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
      pass_thru <= '0;
      row_out   <= '0;
      col_out   <= '0;
    end else begin
      out_valid <= v3_valid;
      pixel_out <= v3_en ? rgb : pix3;
      pass_thru <= pass3;
      row_out   <= row3;
      col_out   <= col3;
    end
  end

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Directed bench for hsv2rgb_pipe with hand-computed RGB values.
module tb_hsv2rgb_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        in_valid;
  logic [12:0] row, col;
  logic [23:0] pixel_in, pass_in;
  logic        out_valid;
  logic [12:0] row_out, col_out;
  logic [23:0] pixel_out, pass_thru;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] pix;
    logic        en;
    logic [23:0] exp;
  } vec_t;

  vec_t q[$];
  vec_t base_vecs[$];

  always #5 clk = ~clk;

  hsv2rgb_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in_valid  (in_valid),
    .row       (row),
    .col       (col),
    .pixel_in  (pixel_in),
    .pass_in   (pass_in),
    .out_valid (out_valid),
    .row_out   (row_out),
    .col_out   (col_out),
    .pixel_out (pixel_out),
    .pass_thru (pass_thru)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] hsv(input int h, input int s, input int v);
    logic [8:0] hh;
    logic [6:0] ss;
    logic [7:0] vv;
    hh = 9'(h);
    ss = 7'(s);
    vv = 8'(v);
    return {hh, ss, vv};
  endfunction

  function automatic vec_t mk(input logic [23:0] pix, input logic e, input logic [23:0] exp);
    vec_t t;
    t.pix = pix;
    t.en  = e;
    t.exp = exp;
    return t;
  endfunction

  // Stream q back-to-back; output after edge i belongs to the pixel driven for edge i-3.
  task automatic run_stream(input string name);
    int n;
    int k;
    n = q.size();
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (i < n) begin
        in_valid = 1'b1;
        pixel_in = q[i].pix;
        en       = q[i].en;
        row      = 13'(100 + i);
        col      = 13'(200 + 2 * i);
        pass_in  = 24'hA50000 + 24'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 3) begin
        k = i - 3;
        check($sformatf("%s_%0d_valid", name, k), 32'(out_valid), 32'd1);
        check($sformatf("%s_%0d_pixel", name, k), 32'(pixel_out), 32'(q[k].exp));
        check($sformatf("%s_%0d_row", name, k), 32'(row_out), 32'(100 + k));
        check($sformatf("%s_%0d_col", name, k), 32'(col_out), 32'(200 + 2 * k));
        check($sformatf("%s_%0d_pass", name, k), 32'(pass_thru), 32'h00A50000 + 32'(k));
      end
    end
  endtask

  initial begin
    logic [3:0] gap_pat;
    reset_n  = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    row      = '0;
    col      = '0;
    pixel_in = '0;
    pass_in  = '0;

    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pixel", 32'(pixel_out), 32'd0);
    check("rst_row", 32'(row_out), 32'd0);
    check("rst_col", 32'(col_out), 32'd0);
    check("rst_pass", 32'(pass_thru), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    base_vecs.push_back(mk(hsv(0,   127, 255), 1'b1, 24'hFF0000));
    base_vecs.push_back(mk(hsv(120, 127, 255), 1'b1, 24'h00FF00));
    base_vecs.push_back(mk(hsv(240, 127, 255), 1'b1, 24'h0000FF));
    base_vecs.push_back(mk(hsv(60,  127, 255), 1'b1, 24'hFFFF00));
    base_vecs.push_back(mk(hsv(30,  127, 255), 1'b1, 24'hFF7F00));
    base_vecs.push_back(mk(hsv(359, 127, 255), 1'b1, 24'hFF0004));
    base_vecs.push_back(mk(hsv(77,  0,   128), 1'b1, 24'h808080));
    base_vecs.push_back(mk(hsv(200, 100, 0),   1'b1, 24'h000000));
    base_vecs.push_back(mk(hsv(400, 127, 255), 1'b1, 24'hFF0000));
    base_vecs.push_back(mk(hsv(300, 127, 255), 1'b1, 24'hFF00FF));
    base_vecs.push_back(mk(hsv(180, 127, 255), 1'b1, 24'h00FFFF));
    base_vecs.push_back(mk(hsv(0,   64,  200), 1'b1, 24'hC86363));

    // all converted
    q = base_vecs;
    run_stream("conv");

    // en toggles every pixel; bypassed pixels must come out bit-identical
    q.delete();
    for (int i = 0; i < base_vecs.size(); i++) begin
      if (i % 2 == 1) q.push_back(mk(base_vecs[i].pix, 1'b0, base_vecs[i].pix));
      else            q.push_back(base_vecs[i]);
    end
    run_stream("mix");

    // in_valid gaps 1,0,0,1 reappear shifted by three edges
    gap_pat = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en       = 1'b1;
      pixel_in = hsv(120, 127, 255);
      in_valid = (i < 4) ? gap_pat[3 - i] : 1'b0;
      @(posedge clk);
      #1;
      if (i >= 3) begin
        if (i - 3 < 4) check($sformatf("gap_valid_%0d", i - 3), 32'(out_valid), 32'(gap_pat[3 - (i - 3)]));
        else           check($sformatf("gap_valid_%0d", i - 3), 32'(out_valid), 32'd0);
      end
    end

    // reset with a full pipe of valid pixels
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      en       = 1'b1;
      pixel_in = hsv(0, 127, 255);
      pass_in  = 24'h123456;
    end
    @(posedge clk);
    #1;
    check("full_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_pixel", 32'(pixel_out), 32'd0);
    check("midrst_pass", 32'(pass_thru), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("relax_valid_%0d", i), 32'(out_valid), (i >= 3) ? 32'd1 : 32'd0);
      if (i >= 3) check($sformatf("relax_pixel_%0d", i), 32'(pixel_out), 32'hFF0000);
    end
    @(negedge clk);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
